// File: rtl/step_motor_driver_pkg.sv
// Shared types and constants for the step motor driver.
// HALF_STEP_EN selects the 8-state half-step sequence; otherwise full-step.
package step_motor_driver_pkg;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // Coil drive bits packed as {AX, AY, BX, BY}
    typedef logic [3:0] coil_t;

    // Entry i is the drive for phase index i (index 7 written first)
    localparam coil_t [7:0] PHASE_TABLE = {
        4'b1000,  // 7: (+, off)
        4'b1001,  // 6: (+, -)
        4'b0001,  // 5: (off, -)
        4'b0101,  // 4: (-, -)
        4'b0100,  // 3: (-, off)
        4'b0110,  // 2: (-, +)
        4'b0010,  // 1: (off, +)
        4'b1010   // 0: (+, +)
    };

`ifdef HALF_STEP_EN
    localparam logic [2:0] STEP_INC = 3'd1;
`else
    localparam logic [2:0] STEP_INC = 3'd2;
`endif

endpackage

// File: rtl/step_motor_phase_decode.sv
// Combinational map from the 3-bit phase index to the coil A/B drive bits.
module step_motor_phase_decode
    import step_motor_driver_pkg::*;
(
    input  logic [2:0] index,
    output logic       ax,
    output logic       ay,
    output logic       bx,
    output logic       by
);

    coil_t coil;

    assign coil = PHASE_TABLE[index];
    assign {ax, ay, bx, by} = coil;

endmodule

// File: rtl/step_motor_driver.sv
// Two-phase bipolar step motor driver with move commands, abort and position tracking.
// Define HALF_STEP_EN for half-stepping; the default build runs full-step.
module step_motor_driver
    import step_motor_driver_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned POS_W = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic [CNT_W-1:0]        cmd_period,
    input  logic                    abort,
    output logic                    AX_step_motor,
    output logic                    AY_step_motor,
    output logic                    BX_step_motor,
    output logic                    BY_step_motor,
    output logic                    AE_step_motor,
    output logic                    BE_step_motor,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic signed [POS_W-1:0] position
);

    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic [2:0]       phase_q;
    logic [2:0]       phase_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] steps_left_q;
    logic             dir_q;
    logic             step_event;
    logic             step_commit;
    logic             ax_d, ay_d, bx_d, by_d;

    // An abort on the same cycle as a step event suppresses that step
    always_comb begin
        step_event  = (state_q == StRun) && (cnt_q == period_q - CNT_ONE);
        step_commit = step_event && !abort;
        phase_d     = phase_q;
        if (step_commit) begin
            phase_d = dir_q ? phase_q + STEP_INC : phase_q - STEP_INC;
        end
    end

    step_motor_phase_decode u_phase_decode (
        .index (phase_d),
        .ax    (ax_d),
        .ay    (ay_d),
        .bx    (bx_d),
        .by    (by_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            phase_q       <= 3'd0;
            cnt_q         <= '0;
            period_q      <= '0;
            steps_left_q  <= '0;
            dir_q         <= 1'b0;
            position      <= '0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            AE_step_motor <= 1'b0;
            BE_step_motor <= 1'b0;
            {AX_step_motor, AY_step_motor, BX_step_motor, BY_step_motor} <= PHASE_TABLE[0];
        end else begin
            done          <= 1'b0;
            aborted       <= 1'b0;
            AE_step_motor <= enable;
            BE_step_motor <= enable;
            phase_q       <= phase_d;
            {AX_step_motor, AY_step_motor, BX_step_motor, BY_step_motor} <=
                {ax_d, ay_d, bx_d, by_d};

            case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state_q      <= StRun;
                            cmd_ready    <= 1'b0;
                            busy         <= 1'b1;
                            dir_q        <= cmd_dir;
                            steps_left_q <= cmd_steps;
                            period_q     <= (cmd_period == '0) ? CNT_ONE : cmd_period;
                            cnt_q        <= '0;
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q   <= StIdle;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        aborted   <= 1'b1;
                        cnt_q     <= '0;
                    end else if (step_event) begin
                        cnt_q        <= '0;
                        position     <= dir_q ? position + POS_ONE : position - POS_ONE;
                        steps_left_q <= steps_left_q - CNT_ONE;
                        if (steps_left_q == CNT_ONE) begin
                            state_q   <= StIdle;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_motor_driver.sv
// Self-checking bench for step_motor_driver: table-driven moves, random moves, corner sequences.
module tb_step_motor_driver;

    localparam int CNT_W = 16;
    localparam int POS_W = 32;
`ifdef HALF_STEP_EN
    localparam int TB_INC = 1;
`else
    localparam int TB_INC = 2;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [CNT_W-1:0] cmd_period;
    logic             abort;
    logic             AX_step_motor, AY_step_motor, BX_step_motor, BY_step_motor;
    logic             AE_step_motor, BE_step_motor;
    logic             busy, done, aborted;
    logic signed [POS_W-1:0] position;

    int checks   = 0;
    int failures = 0;
    int exp_net  = 0;
    logic en_last = 1'b0;

    step_motor_driver #(
        .CNT_W (CNT_W),
        .POS_W (POS_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_dir       (cmd_dir),
        .cmd_steps     (cmd_steps),
        .cmd_period    (cmd_period),
        .abort         (abort),
        .AX_step_motor (AX_step_motor),
        .AY_step_motor (AY_step_motor),
        .BX_step_motor (BX_step_motor),
        .BY_step_motor (BY_step_motor),
        .AE_step_motor (AE_step_motor),
        .BE_step_motor (BE_step_motor),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .position      (position)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic  dir;
        int    steps;
        int    period;
        int    abort_k;   // abort on the k-th step event, 0 = never
        int    exp_end;   // cycles from acceptance to done
        int    exp_delta;
        logic  exp_ab;
    } move_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        en_last = enable;
        @(posedge clock);
        #1;
    endtask

    // Coil drive derived from the (A,B) polarity list of the phase sequence
    function automatic logic [3:0] exp_coil(input int net);
        int idx;
        int a;
        int b;
        idx = (net * TB_INC) % 8;
        if (idx < 0) idx += 8;
        case (idx)
            0: begin a =  1; b =  1; end
            1: begin a =  0; b =  1; end
            2: begin a = -1; b =  1; end
            3: begin a = -1; b =  0; end
            4: begin a = -1; b = -1; end
            5: begin a =  0; b = -1; end
            6: begin a =  1; b = -1; end
            default: begin a = 1; b = 0; end
        endcase
        return {a > 0, a < 0, b > 0, b < 0};
    endfunction

    function automatic logic [3:0] coil_now();
        return {AX_step_motor, AY_step_motor, BX_step_motor, BY_step_motor};
    endfunction

    task automatic check_state(input string name, input int net, input logic exp_busy,
                               input logic exp_done, input logic exp_ab);
        check({name, ".pos"}, {32'b0, position}, {32'b0, 32'(net)});
        check({name, ".coil"}, 64'(coil_now()), 64'(exp_coil(net)));
        check({name, ".busy"}, 64'(busy), 64'(exp_busy));
        check({name, ".ready"}, 64'(cmd_ready), 64'(!exp_busy));
        check({name, ".done"}, 64'(done), 64'(exp_done));
        check({name, ".aborted"}, 64'(aborted), 64'(exp_ab));
        check({name, ".en"}, 64'({AE_step_motor, BE_step_motor}), 64'({en_last, en_last}));
    endtask

    task automatic run_move(input string name, input move_t m);
        int pe, total, end_c, taken, base, first_done;
        logic ab_seen;
        pe    = (m.period == 0) ? 1 : m.period;
        total = (m.abort_k > 0) ? m.abort_k - 1 : m.steps;
        end_c = (m.abort_k > 0) ? m.abort_k * pe : m.steps * pe;
        base  = exp_net;
        check({name, ".ready_pre"}, 64'(cmd_ready), 64'(1));
        cmd_valid  = 1'b1;
        cmd_dir    = m.dir;
        cmd_steps  = CNT_W'(m.steps);
        cmd_period = CNT_W'(m.period);
        tick();
        cmd_valid  = 1'b0;
        cmd_dir    = 1'($urandom_range(0, 1));
        cmd_steps  = CNT_W'($urandom_range(0, 9));
        cmd_period = CNT_W'($urandom_range(0, 9));
        first_done = -1;
        ab_seen    = 1'b0;
        for (int c = 0; c <= end_c + 1; c++) begin
            if (c > 0) begin
                abort  = (m.abort_k > 0) && (c == end_c);
                enable = 1'($urandom_range(0, 1));
                tick();
                abort  = 1'b0;
            end
            taken = c / pe;
            if (taken > total) taken = total;
            check_state($sformatf("%s.c%0d", name, c), base + (m.dir ? taken : -taken),
                        c < end_c, c == end_c, (c == end_c) && (m.abort_k > 0));
            if (done && first_done < 0) begin
                first_done = c;
                ab_seen    = aborted;
            end
        end
        exp_net = base + (m.dir ? total : -total);
        check({name, ".end_cycle"}, 64'(first_done), 64'(m.exp_end));
        check({name, ".end_aborted"}, 64'(ab_seen), 64'(m.exp_ab));
        check({name, ".final_pos"}, {32'b0, position}, {32'b0, 32'(base + m.exp_delta)});
    endtask

    initial begin
        move_t vec [7];
        move_t m;

        //         dir   steps period abort_k end delta aborted
        vec[0] = '{1'b1, 4,    3,     0,      12,  4,   1'b0};
        vec[1] = '{1'b0, 3,    1,     0,      3,  -3,   1'b0};
        vec[2] = '{1'b1, 0,    5,     0,      0,   0,   1'b0};
        vec[3] = '{1'b1, 10,   5,     2,      10,  1,   1'b1};
        vec[4] = '{1'b0, 2,    0,     0,      2,  -2,   1'b0};
        vec[5] = '{1'b0, 5,    2,     1,      2,   0,   1'b1};
        vec[6] = '{1'b1, 1,    4,     0,      4,   1,   1'b0};

        reset      = 1'b1;
        enable     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        tick();
        tick();
        check_state("reset", 0, 1'b0, 1'b0, 1'b0);

        // Enable is registered one cycle; coils at index 0
        reset  = 1'b0;
        enable = 1'b1;
        check("en_before", 64'({AE_step_motor, BE_step_motor}), 64'(2'b00));
        tick();
        check_state("enable", 0, 1'b0, 1'b0, 1'b0);

        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_state("idle_abort", 0, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("idle_abort2", 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_move($sformatf("vec%0d", i), vec[i]);
        end

        for (int i = 0; i < 25; i++) begin
            m.dir     = 1'($urandom_range(0, 1));
            m.steps   = int'($urandom_range(0, 6));
            m.period  = int'($urandom_range(0, 4));
            m.abort_k = (m.steps > 0 && $urandom_range(0, 2) == 0)
                        ? int'($urandom_range(1, m.steps)) : 0;
            m.exp_ab  = m.abort_k > 0;
            m.exp_end = (m.abort_k > 0 ? m.abort_k : m.steps) * ((m.period == 0) ? 1 : m.period);
            m.exp_delta = (m.abort_k > 0) ? m.abort_k - 1 : m.steps;
            if (!m.dir) m.exp_delta = -m.exp_delta;
            run_move($sformatf("rnd%0d", i), m);
        end

        // Reset mid-move discards the move with no done pulse
        enable     = 1'b1;
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = CNT_W'(10);
        cmd_period = CNT_W'(2);
        tick();
        cmd_valid  = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("midmove.busy", 64'(busy), 64'(1));
        reset = 1'b1;
        tick();
        exp_net = 0;
        check("midmove.en", 64'({AE_step_motor, BE_step_motor}), 64'(2'b00));
        check({"midmove", ".pos"}, {32'b0, position}, 64'(0));
        check("midmove.coil", 64'(coil_now()), 64'(4'b1010));
        check("midmove.busy_r", 64'(busy), 64'(0));
        check("midmove.ready_r", 64'(cmd_ready), 64'(1));
        check("midmove.done_r", 64'(done), 64'(0));
        check("midmove.aborted_r", 64'(aborted), 64'(0));
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_state($sformatf("postreset.c%0d", c), 0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_motor_driver.md
STEP_MOTOR_DRIVER -- requirements
Module: step_motor_driver

Interface
REQ-001 Parameter CNT_W, default 16, width of the step count and period fields.
REQ-002 Parameter POS_W, default 32, width of the signed position counter.
REQ-003 clock  input  1  sole clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  coil-driver enable request.
REQ-006 cmd_valid  input  1  move command present.
REQ-007 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid&&cmd_ready at a clock edge.
REQ-008 cmd_dir  input  1  1=forward (phase index up), 0=reverse.
REQ-009 cmd_steps  input  CNT_W  number of steps to move.
REQ-010 cmd_period  input  CNT_W  clocks per step; 0 treated as 1.
REQ-011 abort  input  1  terminate the current move.
REQ-012 AX_step_motor, AY_step_motor, BX_step_motor, BY_step_motor  output  1 each  coil A/B drive: X=1,Y=0 is +; X=0,Y=1 is -; X=Y=0 is off.
REQ-013 AE_step_motor, BE_step_motor  output  1 each  coil A/B driver enable.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse at move end.
REQ-016 aborted  output  1  valid with done; 1 if the move ended by abort.
REQ-017 position  output  POS_W  signed step count, +1 per forward step, -1 per reverse step, two's-complement wrap.

Function
REQ-018 The FSM SHALL have states IDLE and RUN only.
REQ-019 IDLE->RUN on acceptance with cmd_steps>0; cmd_dir, cmd_steps and max(cmd_period,1) are latched at acceptance.
REQ-020 Acceptance with cmd_steps==0 SHALL stay in IDLE and pulse done (aborted=0) on the next cycle, with no motion.
REQ-021 In RUN, the period counter SHALL count 0..period-1; the step event occurs on the cycle the counter equals period-1, so the first step comes period cycles after acceptance.
REQ-022 On each step event: the 3-bit phase index advances ±STEP_INC mod 8, position updates by ±1, and steps_left decrements; the coil outputs change on the same edge.
REQ-023 When the step event decrements steps_left to 0, the FSM SHALL return to IDLE and pulse done (aborted=0) on that edge; cmd_ready is high on the following cycle.
REQ-024 abort in RUN SHALL force IDLE on the next edge, with done=1 and aborted=1 and no step on that edge, even if a step event coincides; abort in IDLE SHALL be ignored.
REQ-025 The phase decode, index 0..7, SHALL be (A,B): (+,+) (off,+) (-,+) (-,off) (-,-) (off,-) (+,-) (+,off).
REQ-026 AE_step_motor=BE_step_motor=enable, registered one cycle; enable SHALL NOT pause or alter the FSM, counters or phase.
REQ-027 Phase index and position SHALL hold in IDLE.

Reset
REQ-028 reset SHALL force the following, overriding all other inputs: IDLE; phase index 0 (AX=1, AY=0, BX=1, BY=0); AE=BE=0; position=0; busy=0; done=0; aborted=0; counters=0.
REQ-029 Reset mid-move SHALL discard the move with no done pulse.

Configuration
REQ-030 With HALF_STEP_EN defined, STEP_INC=1, giving the 8-state half-step sequence.
REQ-031 Without HALF_STEP_EN, STEP_INC=2; the phase index stays even (0, 2, 4, 6), giving full-step two-coil-on operation.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the 8-entry phase decode table and the STEP_INC constant.
REQ-033 One sub-module, step_motor_phase_decode, SHALL map the 3-bit index to AX/AY/BX/BY; the driver SHALL register its outputs.

Verification
REQ-034 Reset, then enable=1 -> AX=1, AY=0, BX=1, BY=0, position=0; AE=BE=1 one cycle after enable.
REQ-035 Full-step build: steps=4, period=3, dir=1 -> step events at 3, 6, 9 and 12 cycles after acceptance; index goes 2, 4, 6, 0; done at the 4th step; position=4.
REQ-036 HALF_STEP_EN build: steps=3, period=1, dir=0 from index 0 -> index 7, 6, 5 on consecutive cycles; position=-3; BY=1 with AX=AY=0 at index 5.
REQ-037 steps=0 -> done=1, aborted=0 one cycle after acceptance; outputs and position unchanged; cmd_ready stays high.
REQ-038 steps=10, period=5, abort asserted on the cycle of the 2nd step event -> position=1, done=1, aborted=1, IDLE next cycle.
REQ-039 period=0 behaves as period=1; reset asserted mid-move -> REQ-028 values and no done pulse.
